fifo_wr_ctl: RTL
================

FIFO_WR_CTL -- requirements
Module: fifo_wr_ctl

Interface
REQ-001 Parameter FIFO_ALMOSTFULL_DEPTH, default 480, fill ceiling (words) a burst may not exceed.
REQ-002 Parameter BURST_LEN, default 16, maximum words per burst (1..255).
REQ-003 Parameter FRAME_WORDS, default 130560, words per LCD frame.
REQ-004 Parameter FRAME_BASE, default 32'h0000_0000, frame-buffer byte base address.
REQ-005 fifo_wr_clk  in  1  sole clock.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 frame_start  in  1  one-cycle pulse, begin fetching a new frame.
REQ-008 fifo_wr_cnt  in  10  FIFO write-side fill count.
REQ-009 fifo_full  in  1  FIFO full flag.
REQ-010 fifo_wr_en  out  1  FIFO write strobe.
REQ-011 fifo_wr_data  out  32  FIFO write data.
REQ-012 burst_req  out  1  burst request to frame-buffer reader.
REQ-013 burst_addr  out  32  burst start byte address.
REQ-014 burst_len  out  8  burst length in words.
REQ-015 burst_ack  in  1  reader accepted request.
REQ-016 src_valid  in  1  pixel word valid.
REQ-017 src_data  in  32  pixel word.
REQ-018 src_ready  out  1  controller accepts word this cycle.
REQ-019 frame_done  out  1  one-cycle pulse, last frame word written.
REQ-020 wr_ovf  out  1  sticky overflow error.

Function
REQ-021 States IDLE, CHECK, REQ, DATA; IDLE after reset.
REQ-022 IDLE: frame_start -> clear word_cnt to 0, go CHECK; else stay.
REQ-023 CHECK: len = min(BURST_LEN, FRAME_WORDS - word_cnt); go REQ when fifo_wr_cnt + len <= FIFO_ALMOSTFULL_DEPTH, sum computed 11 bits wide with no wrap.
REQ-024 REQ: burst_req=1, burst_addr = FRAME_BASE + 4*word_cnt, burst_len = len, all held stable until burst_ack; burst_ack -> DATA, beat_cnt cleared.
REQ-025 DATA: src_ready = !fifo_full; beat accepted when src_valid && src_ready.
REQ-026 Accepted beat -> fifo_wr_en=1, fifo_wr_data=src_data on the next clock edge (latency 1); fifo_wr_en=0 in all other cycles.
REQ-027 On acceptance of beat number len: word_cnt += len; word_cnt == FRAME_WORDS -> frame_done pulse (same cycle as final fifo_wr_en), go IDLE; else go CHECK.
REQ-028 frame_start in CHECK -> restart: word_cnt=0, stay CHECK.
REQ-029 frame_start in REQ or DATA -> latched pending; current burst completes; then word_cnt=0, pending cleared, go CHECK, no frame_done.
REQ-030 src_valid outside DATA ignored, never written.
REQ-031 Final burst of a frame is short when FRAME_WORDS is not a multiple of BURST_LEN.

Reset
REQ-032 rst asserted, any cycle including mid-burst: state=IDLE, word_cnt=0, beat_cnt=0, pending=0, wr_ovf=0, and fifo_wr_en, burst_req, src_ready, frame_done=0, fifo_wr_data=0, burst_addr=0, burst_len=0, immediately (asynchronously).
REQ-033 Release is synchronous to fifo_wr_clk; first frame_start is honoured on the first edge after release.

Configuration
REQ-034 Macro FIFO_WR_OVF_EN defined: src_valid && fifo_full in DATA sets wr_ovf, cleared only by rst.
REQ-035 FIFO_WR_OVF_EN undefined: wr_ovf tied 0, no detection logic; the rest of the behaviour is identical.

Verification (BURST_LEN=16, FIFO_ALMOSTFULL_DEPTH=480, FRAME_WORDS=40, FRAME_BASE=32'h1000)
REQ-036 fifo_wr_cnt=0, frame_start, 0-cycle-latency source -> bursts at 0x1000/16, 0x1040/16, 0x1080/8; 40 writes, data in order; frame_done coincides with the 40th fifo_wr_en.
REQ-037 fifo_wr_cnt=470 held -> burst_req stays 0; drop fifo_wr_cnt to 464 -> burst_req at 0x1000, len 16.
REQ-038 burst_ack delayed 5 cycles -> burst_req, burst_addr, and burst_len are stable for all 5 cycles; a single burst is issued.
REQ-039 frame_start on beat 7 of burst 2 -> burst 2 completes all 16 beats; the next burst addr is 0x1000; no frame_done.
REQ-040 fifo_full=1 for 3 cycles mid-burst with src_valid high -> src_ready=0 and no writes; with FIFO_WR_OVF_EN defined wr_ovf=1, otherwise wr_ovf=0.
REQ-041 rst pulsed during DATA -> all outputs 0 asynchronously, state IDLE; a new frame_start restarts at 0x1000.

Source files
------------

// File: rtl/fifo_wr_ctl.sv
// Frame-buffer to LCD FIFO write controller: requests bursts that fit under the FIFO fill ceiling and streams their words into the FIFO.
// Optional macro FIFO_WR_OVF_EN enables the sticky wr_ovf detector (source valid while FIFO full).
module fifo_wr_ctl #(
  parameter int unsigned FIFO_ALMOSTFULL_DEPTH = 480,
  parameter int unsigned BURST_LEN             = 16,
  parameter int unsigned FRAME_WORDS           = 130560,
  parameter logic [31:0] FRAME_BASE            = 32'h0000_0000
) (
  input  logic        fifo_wr_clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic [9:0]  fifo_wr_cnt,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [31:0] fifo_wr_data,
  output logic        burst_req,
  output logic [31:0] burst_addr,
  output logic [7:0]  burst_len,
  input  logic        burst_ack,
  input  logic        src_valid,
  input  logic [31:0] src_data,
  output logic        src_ready,
  output logic        frame_done,
  output logic        wr_ovf
);

  localparam int unsigned WCW = $clog2(FRAME_WORDS + 1);
  localparam int unsigned FW  = 11;

  typedef enum logic [1:0] {IDLE, CHECK, REQ, DATA} state_e;

  state_e          state_q, state_d;
  logic [WCW-1:0]  word_cnt_q, word_cnt_d;
  logic [7:0]      beat_cnt_q, beat_cnt_d;
  logic            pending_q, pending_d;
  logic            fifo_wr_en_q, fifo_wr_en_d;
  logic [31:0]     fifo_wr_data_q, fifo_wr_data_d;
  logic            burst_req_q, burst_req_d;
  logic [31:0]     burst_addr_q, burst_addr_d;
  logic [7:0]      burst_len_q, burst_len_d;
  logic            frame_done_q, frame_done_d;

  logic [WCW-1:0]  rem_c;
  logic [7:0]      len_c;
  logic [FW-1:0]   fill_c;
  logic            fits_c;
  logic            src_ready_c;
  logic            accept_c;
  logic            last_beat_c;
  logic            restart_c;
  logic [WCW-1:0]  word_sum_c;

  // Next burst size (short at the end of a frame) and whether it fits under the ceiling
  assign rem_c       = WCW'(FRAME_WORDS) - word_cnt_q;
  assign len_c       = (32'(rem_c) < BURST_LEN) ? 8'(rem_c) : 8'(BURST_LEN);
  assign fill_c      = FW'(fifo_wr_cnt) + FW'(len_c);
  assign fits_c      = (fill_c <= FW'(FIFO_ALMOSTFULL_DEPTH));

  // src_ready must react to fifo_full in the same cycle, so it is decoded, not registered
  assign src_ready_c = (state_q == DATA) && !fifo_full;
  assign accept_c    = src_ready_c && src_valid;
  assign last_beat_c = accept_c && (beat_cnt_q == burst_len_q - 8'd1);
  assign restart_c   = pending_q || frame_start;
  assign word_sum_c  = word_cnt_q + WCW'(burst_len_q);

  always_comb begin
    state_d        = state_q;
    word_cnt_d     = word_cnt_q;
    beat_cnt_d     = beat_cnt_q;
    pending_d      = pending_q;
    fifo_wr_en_d   = accept_c;
    fifo_wr_data_d = accept_c ? src_data : fifo_wr_data_q;
    burst_req_d    = burst_req_q;
    burst_addr_d   = burst_addr_q;
    burst_len_d    = burst_len_q;
    frame_done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          word_cnt_d = '0;
          state_d    = CHECK;
        end
      end
      CHECK: begin
        if (frame_start) begin
          word_cnt_d = '0;
        end else if (fits_c) begin
          state_d      = REQ;
          burst_req_d  = 1'b1;
          burst_addr_d = FRAME_BASE + (32'(word_cnt_q) << 2);
          burst_len_d  = len_c;
        end
      end
      REQ: begin
        pending_d = restart_c;
        if (burst_ack) begin
          burst_req_d = 1'b0;
          beat_cnt_d  = '0;
          state_d     = DATA;
        end
      end
      DATA: begin
        pending_d = restart_c;
        if (accept_c) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
        end
        // A restart requested mid-burst takes effect only once the burst has drained
        if (last_beat_c) begin
          if (restart_c) begin
            word_cnt_d = '0;
            pending_d  = 1'b0;
            state_d    = CHECK;
          end else if (word_sum_c == WCW'(FRAME_WORDS)) begin
            word_cnt_d   = word_sum_c;
            frame_done_d = 1'b1;
            state_d      = IDLE;
          end else begin
            word_cnt_d = word_sum_c;
            state_d    = CHECK;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge fifo_wr_clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      word_cnt_q     <= '0;
      beat_cnt_q     <= '0;
      pending_q      <= 1'b0;
      fifo_wr_en_q   <= 1'b0;
      fifo_wr_data_q <= '0;
      burst_req_q    <= 1'b0;
      burst_addr_q   <= '0;
      burst_len_q    <= '0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      word_cnt_q     <= word_cnt_d;
      beat_cnt_q     <= beat_cnt_d;
      pending_q      <= pending_d;
      fifo_wr_en_q   <= fifo_wr_en_d;
      fifo_wr_data_q <= fifo_wr_data_d;
      burst_req_q    <= burst_req_d;
      burst_addr_q   <= burst_addr_d;
      burst_len_q    <= burst_len_d;
      frame_done_q   <= frame_done_d;
    end
  end

`ifdef FIFO_WR_OVF_EN
  logic wr_ovf_q, wr_ovf_d;

  // Sticky: the source offered a word while the FIFO could not take it
  always_comb begin
    wr_ovf_d = wr_ovf_q;
    if ((state_q == DATA) && src_valid && fifo_full) begin
      wr_ovf_d = 1'b1;
    end
  end

  always_ff @(posedge fifo_wr_clk or posedge rst) begin
    if (rst) begin
      wr_ovf_q <= 1'b0;
    end else begin
      wr_ovf_q <= wr_ovf_d;
    end
  end

  assign wr_ovf = wr_ovf_q;
`else
  assign wr_ovf = 1'b0;
`endif

  assign fifo_wr_en   = fifo_wr_en_q;
  assign fifo_wr_data = fifo_wr_data_q;
  assign burst_req    = burst_req_q;
  assign burst_addr   = burst_addr_q;
  assign burst_len    = burst_len_q;
  assign src_ready    = src_ready_c;
  assign frame_done   = frame_done_q;

endmodule
